// File: rtl/comps_pipe_if.sv
// comps_pipe_if: input/output handshake bundle for comps_pipe
interface comps_pipe_if #(
  parameter int W = 8,
  parameter int LANES = 2,
  parameter int CNT_W = 16
);
  logic in_valid, in_ready, out_valid, out_ready;
  logic [2:0] op;
  logic [LANES*W-1:0] a, b, y;
  logic [LANES-1:0] zero;
  logic [$clog2(W+1)-1:0] pop0;
  logic [CNT_W-1:0] txn_count;
  modport master (
    output in_valid, op, a, b, out_ready,
    input in_ready, out_valid, y, zero, pop0, txn_count
  );
  modport slave (
    input in_valid, op, a, b, out_ready,
    output in_ready, out_valid, y, zero, pop0, txn_count
  );
endinterface

// File: rtl/comps_pipe.sv
// comps_pipe: per-lane selectable bitwise ops through a two-stage valid/ready pipeline
module comps_pipe #(
  parameter int W = 8,
  parameter int LANES = 2,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  comps_pipe_if.slave bus
);
  localparam int PW = $clog2(W + 1);
  logic s1_valid, out_valid, s2_load, in_ready, in_fire, out_fire;
  logic [LANES*W-1:0] s1_d, s1_y, y;
  logic [LANES-1:0] zero_d, zero;
  logic [PW-1:0] pop0;
  logic [CNT_W-1:0] txn_count;
  function automatic logic [W-1:0] lane_op(input logic [2:0] o, input logic [W-1:0] x, z);
    case (o)
      3'd0: lane_op = ~x;
      3'd1: lane_op = x & z;
      3'd2: lane_op = x | z;
      3'd3: lane_op = x ^ z;
      3'd4: lane_op = ~(x & z);
      3'd5: lane_op = ~(x | z);
      3'd6: lane_op = ~(x ^ z);
      default: lane_op = z;
    endcase
  endfunction
  always_comb begin
    s1_d = '0;
    zero_d = '0;
    for (int i = 0; i < LANES; i++) begin
      s1_d[i*W +: W] = lane_op(bus.op, bus.a[i*W +: W], bus.b[i*W +: W]);
      zero_d[i] = ~|s1_y[i*W +: W];
    end
  end
  assign out_fire = out_valid && bus.out_ready;
  assign s2_load = s1_valid && (!out_valid || bus.out_ready);
  assign in_ready = rst_n && (!s1_valid || s2_load);
  assign in_fire = bus.in_valid && in_ready;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_y <= '0;
      out_valid <= 1'b0;
      y <= '0;
      zero <= '0;
      pop0 <= '0;
      txn_count <= '0;
    end else begin
      if (in_fire) s1_y <= s1_d;
      s1_valid <= in_fire || (s1_valid && !s2_load);
      if (s2_load) begin
        y <= s1_y;
        zero <= zero_d;
        pop0 <= PW'($countones(s1_y[W-1:0]));
      end
      out_valid <= s2_load || (out_valid && !bus.out_ready);
      if (out_fire) txn_count <= txn_count + CNT_W'(1);
    end
  end
  assign bus.in_ready = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.y = y;
  assign bus.zero = zero;
  assign bus.pop0 = pop0;
  assign bus.txn_count = txn_count;
endmodule
